// File: rtl/output_merger.sv
// Reassembles per-PIM-unit result blocks (row-major streams) into one square result matrix.
// Define OUTPUT_MERGER_STALL_CNT_EN to add the stall_cycles output.
module output_merger #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_PIM_UNITS   = 4,
    parameter int unsigned MAX_MATRIX_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              matrix_size,
    input  logic [NUM_PIM_UNITS-1:0] unit_valid,
    input  logic [DATA_WIDTH-1:0]    unit_data [0:NUM_PIM_UNITS-1],
    output logic [NUM_PIM_UNITS-1:0] unit_ready,
    output logic                     busy,
    output logic                     merge_done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    result [0:MAX_MATRIX_SIZE-1][0:MAX_MATRIX_SIZE-1]
`ifdef OUTPUT_MERGER_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int unsigned CW = $clog2(((MAX_MATRIX_SIZE > NUM_PIM_UNITS) ?
                                         MAX_MATRIX_SIZE : NUM_PIM_UNITS) + 1);
    localparam int unsigned IW = $clog2(MAX_MATRIX_SIZE);
    localparam int unsigned UW = $clog2(NUM_PIM_UNITS);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cur_q, i_q, j_q, alloc_q, chunk_q;
    logic [UW-1:0]   cur_idx;
    logic [IW-1:0]   row, col;
    logic            size_ok, size_full, xfer, j_last, i_last, cur_last;

    assign size_ok   = (matrix_size != 32'd0) && (matrix_size <= MAX_MATRIX_SIZE);
    assign size_full = (matrix_size == MAX_MATRIX_SIZE);
    assign cur_idx   = UW'(cur_q);
    assign xfer      = (state_q == StCollect) && unit_valid[cur_idx];
    assign j_last    = (j_q == chunk_q - 1'b1);
    assign i_last    = (i_q == chunk_q - 1'b1);
    assign cur_last  = (cur_q == alloc_q - 1'b1);

    // Quadrant origin: block row cur/2, block col cur%2.
    assign row = IW'(((cur_q >> 1) * chunk_q) + i_q);
    assign col = IW'(((cur_q & CW'(1)) * chunk_q) + j_q);

    assign busy       = (state_q != StIdle);
    assign merge_done = (state_q == StDone);

    always_comb begin
        unit_ready = '0;
        if (state_q == StCollect) begin
            unit_ready[cur_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && size_ok) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (xfer && j_last && i_last && cur_last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cur_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            alloc_q <= '0;
            chunk_q <= '0;
            error   <= 1'b0;
            for (int unsigned r = 0; r < MAX_MATRIX_SIZE; r++) begin
                for (int unsigned c = 0; c < MAX_MATRIX_SIZE; c++) begin
                    result[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (size_ok) begin
                            alloc_q <= size_full ? CW'(NUM_PIM_UNITS) : CW'(1);
                            chunk_q <= size_full ? CW'(MAX_MATRIX_SIZE / 2) : CW'(matrix_size);
                            cur_q   <= '0;
                            i_q     <= '0;
                            j_q     <= '0;
                            error   <= 1'b0;
                            for (int unsigned r = 0; r < MAX_MATRIX_SIZE; r++) begin
                                for (int unsigned c = 0; c < MAX_MATRIX_SIZE; c++) begin
                                    result[r][c] <= '0;
                                end
                            end
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (xfer) begin
                        result[row][col] <= unit_data[cur_idx];
                        if (j_last) begin
                            j_q <= '0;
                            if (i_last) begin
                                i_q   <= '0;
                                cur_q <= cur_q + 1'b1;
                            end else begin
                                i_q <= i_q + 1'b1;
                            end
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OUTPUT_MERGER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state_q == StIdle) && start && size_ok) begin
            stall_cycles <= '0;
        end else if ((state_q == StCollect) && !unit_valid[cur_idx] && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_merger.sv
// Self-checking bench for output_merger: randomized streams checked against a
// matrix-level reference model built from the quadrant placement rules.
module tb_output_merger;

    localparam int DW = 32;
    localparam int NU = 4;
    localparam int MX = 8;
    localparam int HF = MX / 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   matrix_size;
    logic [NU-1:0] unit_valid;
    logic [DW-1:0] unit_data [0:NU-1];
    logic [NU-1:0] unit_ready;
    logic          busy;
    logic          merge_done;
    logic          error;
    logic [DW-1:0] result [0:MX-1][0:MX-1];
`ifdef OUTPUT_MERGER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    output_merger #(
        .DATA_WIDTH     (DW),
        .NUM_PIM_UNITS  (NU),
        .MAX_MATRIX_SIZE(MX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matrix_size (matrix_size),
        .unit_valid  (unit_valid),
        .unit_data   (unit_data),
        .unit_ready  (unit_ready),
        .busy        (busy),
        .merge_done  (merge_done),
        .error       (error),
        .result      (result)
`ifdef OUTPUT_MERGER_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] src   [0:NU-1][0:HF*HF-1];
    logic [DW-1:0] exp_m [0:MX-1][0:MX-1];

    // Results of the last stream() run
    int nxfer, done_cnt, done_at, last_c, ready_err, stall_exp;
    logic busy_after;

    task automatic fill_src(input int pattern);
        for (int u = 0; u < NU; u++)
            for (int k = 0; k < HF * HF; k++)
                src[u][k] = (pattern == 1) ? DW'(u * 16 + k + 0) :
                            (pattern == 2) ? DW'(k + 1) : DW'($urandom);
    endtask

    // Whole-matrix view: small sizes come entirely from unit 0, full size is a 2x2 grid.
    task automatic build_expected(input int size);
        for (int r = 0; r < MX; r++)
            for (int c = 0; c < MX; c++) begin
                exp_m[r][c] = '0;
                if (size < MX) begin
                    if (r < size && c < size) exp_m[r][c] = src[0][r * size + c];
                end else begin
                    exp_m[r][c] = src[(r / HF) * 2 + c / HF][(r % HF) * HF + c % HF];
                end
            end
    endtask

    task automatic clear_expected();
        for (int r = 0; r < MX; r++)
            for (int c = 0; c < MX; c++) exp_m[r][c] = '0;
    endtask

    task automatic diff_result(output int bad);
        bad = 0;
        for (int r = 0; r < MX; r++)
            for (int c = 0; c < MX; c++)
                if (result[r][c] !== exp_m[r][c]) bad++;
    endtask

    task automatic do_start(input int size);
        @(negedge clk);
        start       = 1'b1;
        matrix_size = 32'(size);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: alternating, 2: random bubbles.
    task automatic stream(input int size, input int mode, input int ghost_c, input int abort_after);
        int alloc, chunk, per, total, cur;
        bit drove, stop;
        logic [NU-1:0] exp_ready;
        alloc = (size == MX) ? NU : 1;
        chunk = (size == MX) ? HF : size;
        per   = chunk * chunk;
        total = alloc * per;
        nxfer = 0; done_cnt = 0; done_at = -1; last_c = -1; ready_err = 0; stall_exp = 0;
        busy_after = 1'b1;
        drove = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 1000 && !stop; c++) begin
            if (drove) begin
                nxfer++;
                if (nxfer == total) last_c = c;
            end
            drove = 1'b0;
            if (abort_after > 0 && nxfer == abort_after) begin
                unit_valid = '0;
                stop = 1'b1;
            end else begin
                cur = (nxfer < total) ? nxfer / per : 0;
                exp_ready = (nxfer < total) ? NU'(1 << cur) : '0;
                if (unit_ready !== exp_ready) ready_err++;
                if (merge_done === 1'b1) begin
                    done_cnt++;
                    if (done_at < 0) done_at = c;
                end
                if (last_c >= 0 && c == last_c + 1) begin
                    busy_after = busy;
                    stop = 1'b1;
                end
                start = (c == ghost_c);
                if (c == ghost_c) matrix_size = 32'd2;
                for (int u = 0; u < NU; u++) begin
                    unit_valid[u] = 1'b0;
                    unit_data[u]  = DW'($urandom);
                    if (nxfer < total && !stop) begin
                        if (u == cur) begin
                            unit_valid[u] = (mode == 0) ? 1'b1 :
                                            (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
                            unit_data[u]  = src[u][nxfer % per];
                            drove = unit_valid[u];
                            if (!unit_valid[u]) stall_exp++;
                        end else begin
                            unit_valid[u] = 1'b1;
                        end
                    end
                end
                if (!stop) @(negedge clk);
            end
        end
        unit_valid = '0;
        start      = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; start = 1'b0; matrix_size = '0; unit_valid = '0;
        for (int u = 0; u < NU; u++) unit_data[u] = '0;
        repeat (3) @(negedge clk);
        clear_expected();
        diff_result(bad);
        n_checks++;
        if ({busy, merge_done, error, unit_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {busy, merge_done, error, unit_ready});
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL reset_result: %0d nonzero entries, required 0", bad);
        end
`ifdef OUTPUT_MERGER_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_small();
        int bad;
        fill_src(2);
        do_start(3);
        stream(3, 0, -1, 0);
        build_expected(3);
        diff_result(bad);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL small_result: %0d bad entries, required 0", bad); end
        n_checks++;
        if (result[0][1] !== 32'd2 || result[2][2] !== 32'd9) begin
            n_fail++;
            $display("FAIL small_corners: got %0d/%0d required 2/9", result[0][1], result[2][2]);
        end
        n_checks++;
        if (ready_err !== 0) begin n_fail++; $display("FAIL small_ready: %0d bad cycles, required 0", ready_err); end
        n_checks++;
        if (done_cnt !== 1 || done_at !== last_c || last_c < 0) begin
            n_fail++;
            $display("FAIL small_done: count %0d at %0d, required 1 at %0d", done_cnt, done_at, last_c);
        end
        n_checks++;
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL small_busy: got %b required 0", busy_after); end
    endtask

    task automatic test_full(input int ghost_c);
        int bad;
        fill_src(1);
        do_start(MX);
        stream(MX, 0, ghost_c, 0);
        build_expected(MX);
        diff_result(bad);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL full_result: %0d bad entries, required 0", bad); end
        n_checks++;
        if (result[0][4] !== 32'd16 || result[4][0] !== 32'd32 || result[7][7] !== 32'd63) begin
            n_fail++;
            $display("FAIL full_quadrants: got %0d/%0d/%0d required 16/32/63",
                     result[0][4], result[4][0], result[7][7]);
        end
        n_checks++;
        if (ready_err !== 0) begin n_fail++; $display("FAIL full_ready: %0d bad cycles, required 0", ready_err); end
        n_checks++;
        if (nxfer !== 64 || done_cnt !== 1 || done_at !== last_c) begin
            n_fail++;
            $display("FAIL full_done: xfers %0d done %0d at %0d, required 64 1 at %0d",
                     nxfer, done_cnt, done_at, last_c);
        end
    endtask

    task automatic test_bubbles();
        int bad;
        fill_src(0);
        do_start(2);
        stream(2, 1, -1, 0);
        build_expected(2);
        diff_result(bad);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL bubble_result: %0d bad entries, required 0", bad); end
        n_checks++;
        if (done_cnt !== 1 || ready_err !== 0) begin
            n_fail++; $display("FAIL bubble_done: done %0d ready errs %0d, required 1 0", done_cnt, ready_err);
        end
`ifdef OUTPUT_MERGER_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd3) begin
            n_fail++; $display("FAIL bubble_stall: got %0d required 3", stall_cycles);
        end
`endif
    endtask

    task automatic test_illegal();
        int bad;
        @(negedge clk); start = 1'b1; matrix_size = 32'd0;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if ({error, busy, unit_ready} !== {1'b1, 1'b0, 4'b0}) begin
            n_fail++; $display("FAIL illegal_zero: got %b required 100000", {error, busy, unit_ready});
        end
        @(negedge clk); start = 1'b1; matrix_size = 32'd9;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        diff_result(bad);
        n_checks++;
        if ({error, busy, unit_ready} !== {1'b1, 1'b0, 4'b0} || bad !== 0) begin
            n_fail++;
            $display("FAIL illegal_nine: flags %b bad entries %0d, required 100000 and 0",
                     {error, busy, unit_ready}, bad);
        end
        fill_src(0);
        do_start(2);
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL illegal_recover: error %b busy %b, required 0 1", error, busy);
        end
        stream(2, 0, -1, 0);
        build_expected(2);
        diff_result(bad);
        n_checks++;
        if (bad !== 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL illegal_merge: bad %0d done %0d, required 0 1", bad, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_src(0);
        do_start(MX);
        stream(MX, 0, -1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_expected();
        diff_result(bad);
        n_checks++;
        if (busy !== 1'b0 || unit_ready !== '0 || bad !== 0 || nxfer !== 5) begin
            n_fail++;
            $display("FAIL midreset: busy %b ready %b bad %0d xfers %0d, required 0 0000 0 5",
                     busy, unit_ready, bad, nxfer);
        end
        fill_src(0);
        do_start(4);
        stream(4, 0, -1, 0);
        build_expected(4);
        diff_result(bad);
        n_checks++;
        if (bad !== 0 || done_cnt !== 1 || ready_err !== 0) begin
            n_fail++;
            $display("FAIL midreset_merge: bad %0d done %0d ready errs %0d, required 0 1 0",
                     bad, done_cnt, ready_err);
        end
    endtask

    task automatic test_random();
        int bad, size;
        for (int it = 0; it < 8; it++) begin
            size = (it == 0) ? MX : (it == 1) ? 1 : $urandom_range(1, MX);
            fill_src(0);
            do_start(size);
            stream(size, 2, -1, 0);
            build_expected(size);
            diff_result(bad);
            n_checks++;
            if (bad !== 0 || done_cnt !== 1 || ready_err !== 0 || busy_after !== 1'b0) begin
                n_fail++;
                $display("FAIL random_size%0d: bad %0d done %0d ready errs %0d busy %b, required 0 1 0 0",
                         size, bad, done_cnt, ready_err, busy_after);
            end
`ifdef OUTPUT_MERGER_STALL_CNT_EN
            n_checks++;
            if (stall_cycles !== 32'(stall_exp)) begin
                n_fail++; $display("FAIL random_stall: got %0d required %0d", stall_cycles, stall_exp);
            end
`endif
            // Result must hold after DONE
            repeat (3) @(negedge clk);
            diff_result(bad);
            n_checks++;
            if (bad !== 0) begin n_fail++; $display("FAIL random_hold: %0d bad entries, required 0", bad); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_small();
        test_full(-1);
        test_bubbles();
        test_illegal();
        test_reset_mid();
        test_full(10);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
